// File: rtl/spi_arb.sv
// rtl/spi_arb.sv - round-robin arbiter sharing one SPI_mnrch between A2D (req 0) and inertial (req 1); optional SPI_ARB_CNT_EN adds grant counters
module spi_arb #(
   parameter int HOLD_TMO = 8,
   parameter int DW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    wrt_i,
   input  logic [DW-1:0] wt_data0_i,
   input  logic [DW-1:0] wt_data1_i,
   input  logic [1:0]    hold_i,
   output logic [1:0]    done_o,
   output logic [DW-1:0] rd_data_o,
   output logic [1:0]    gnt_o,
   output logic          m_wrt,
   output logic [DW-1:0] m_wt_data,
   input  logic          m_done,
   input  logic [DW-1:0] m_rd_data,
   input  logic          m_SS_n,
   output logic [1:0]    SS_n_o
`ifdef SPI_ARB_CNT_EN
   ,
   input  logic          cnt_clr_i,
   output logic [15:0]   gnt_cnt0_o,
   output logic [15:0]   gnt_cnt1_o
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   state_t        state, state_nxt;
   logic [1:0]    pend, pend_nxt;
   logic [DW-1:0] data0, data0_nxt;
   logic [DW-1:0] data1, data1_nxt;
   logic [1:0]    hold_l, hold_l_nxt;
   logic          cur_hold, cur_hold_nxt;
   logic          rr, rr_nxt;
   logic          owner, owner_nxt;
   logic [7:0]    tmr, tmr_nxt;
   logic [1:0]    gnt_nxt;
   logic          m_wrt_nxt;
   logic [DW-1:0] m_wt_data_nxt;
   logic [1:0]    done_nxt;
   logic [DW-1:0] rd_nxt;

   logic [1:0]    new_req;
   logic [1:0]    eff_pend;
   logic [DW-1:0] eff_data0, eff_data1;
   logic [1:0]    eff_hold;
   logic          win;

   // Request capture with bypass: a fresh request is visible to the FSM in the cycle it arrives
   always_comb begin
      new_req     = wrt_i & ~pend;
      eff_pend    = pend | wrt_i;
      eff_data0   = new_req[0] ? wt_data0_i : data0;
      eff_data1   = new_req[1] ? wt_data1_i : data1;
      eff_hold[0] = new_req[0] ? hold_i[0] : hold_l[0];
      eff_hold[1] = new_req[1] ? hold_i[1] : hold_l[1];
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nxt     = state;
      pend_nxt      = eff_pend;
      data0_nxt     = eff_data0;
      data1_nxt     = eff_data1;
      hold_l_nxt    = eff_hold;
      cur_hold_nxt  = cur_hold;
      rr_nxt        = rr;
      owner_nxt     = owner;
      tmr_nxt       = tmr;
      gnt_nxt       = gnt_o;
      m_wrt_nxt     = 1'b0;
      m_wt_data_nxt = m_wt_data;
      done_nxt      = 2'b00;
      rd_nxt        = rd_data_o;
      win           = rr;

      case (state)
         IDLE: begin
            if (|eff_pend) begin
               win           = (eff_pend == 2'b11) ? rr : eff_pend[1];
               owner_nxt     = win;
               gnt_nxt       = win ? 2'b10 : 2'b01;
               m_wrt_nxt     = 1'b1;
               m_wt_data_nxt = win ? eff_data1 : eff_data0;
               cur_hold_nxt  = eff_hold[win];
               pend_nxt[win] = 1'b0;
               state_nxt     = BUSY;
            end
         end
         BUSY: begin
            if (m_done) begin
               rd_nxt   = m_rd_data;
               done_nxt = owner ? 2'b10 : 2'b01;
               rr_nxt   = ~owner;
               if (cur_hold) begin
                  tmr_nxt   = 8'(HOLD_TMO);
                  state_nxt = HOLD;
               end else begin
                  gnt_nxt   = 2'b00;
                  state_nxt = IDLE;
               end
            end
         end
         HOLD: begin
            if (eff_pend[owner]) begin
               m_wrt_nxt       = 1'b1;
               m_wt_data_nxt   = owner ? eff_data1 : eff_data0;
               cur_hold_nxt    = eff_hold[owner];
               pend_nxt[owner] = 1'b0;
               state_nxt       = BUSY;
            end else if (tmr <= 8'd1) begin
               tmr_nxt   = 8'd0;
               gnt_nxt   = 2'b00;
               state_nxt = IDLE;
            end else begin
               tmr_nxt = tmr - 8'd1;
            end
         end
         default: begin
            gnt_nxt   = 2'b00;
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops everything in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pend      <= 2'b00;
         data0     <= '0;
         data1     <= '0;
         hold_l    <= 2'b00;
         cur_hold  <= 1'b0;
         rr        <= 1'b0;
         owner     <= 1'b0;
         tmr       <= 8'd0;
         gnt_o     <= 2'b00;
         m_wrt     <= 1'b0;
         m_wt_data <= '0;
         done_o    <= 2'b00;
         rd_data_o <= '0;
      end else begin
         state     <= state_nxt;
         pend      <= pend_nxt;
         data0     <= data0_nxt;
         data1     <= data1_nxt;
         hold_l    <= hold_l_nxt;
         cur_hold  <= cur_hold_nxt;
         rr        <= rr_nxt;
         owner     <= owner_nxt;
         tmr       <= tmr_nxt;
         gnt_o     <= gnt_nxt;
         m_wrt     <= m_wrt_nxt;
         m_wt_data <= m_wt_data_nxt;
         done_o    <= done_nxt;
         rd_data_o <= rd_nxt;
      end
   end

   assign SS_n_o = {2{m_SS_n}} | ~gnt_o;

`ifdef SPI_ARB_CNT_EN
   // Saturating per-requester count of issued write strobes; clear wins over increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_cnt0_o <= 16'h0000;
         gnt_cnt1_o <= 16'h0000;
      end else if (cnt_clr_i) begin
         gnt_cnt0_o <= 16'h0000;
         gnt_cnt1_o <= 16'h0000;
      end else if (m_wrt) begin
         if (gnt_o[0] && (gnt_cnt0_o != 16'hFFFF)) gnt_cnt0_o <= gnt_cnt0_o + 16'd1;
         if (gnt_o[1] && (gnt_cnt1_o != 16'hFFFF)) gnt_cnt1_o <= gnt_cnt1_o + 16'd1;
      end
   end
`endif

endmodule

// File: doc/spi_arb.md
Name: spi_arb

Overview:
- Arbiter/sequencer that shares one SPI_mnrch instance between two requesters: requester 0 = A2D interface, requester 1 = inertial sensor interface.
- Latches write requests, grants the SPI monarch round-robin, and routes done/rd_data back to the winner.
- Steers a per-device active-low select.
- Supports a "hold" grant so a requester can keep the bus across back-to-back transactions, e.g. the A2D channel-select + read pair.

Parameters:
- HOLD_TMO, 8: cycles a held grant waits for the holder's next wrt before release (1..255).
- DW, 16: SPI transaction data width.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous active-high reset
- wrt_i  in  2  per-requester one-cycle write request; bit i = requester i
- wt_data0_i  in  DW  requester 0 transmit word, sampled with wrt_i[0]
- wt_data1_i  in  DW  requester 1 transmit word, sampled with wrt_i[1]
- hold_i  in  2  sampled with wrt_i[i]; 1 = keep grant after this transaction
- done_o  out  2  one-cycle completion pulse to requester i
- rd_data_o  out  DW  registered received word, valid with done_o, held until next completion
- gnt_o  out  2  one-hot current grant, 00 = none
- m_wrt  out  1  write strobe to SPI_mnrch
- m_wt_data  out  DW  transmit word to SPI_mnrch
- m_done  in  1  SPI_mnrch done
- m_rd_data  in  DW  SPI_mnrch rd_data
- m_SS_n  in  1  SPI_mnrch SS_n
- SS_n_o  out  2  per-device select: SS_n_o[i] = m_SS_n | ~gnt_o[i]

Behaviour:
- Reset values: gnt_o=00, m_wrt=0, m_wt_data=0, done_o=00, rd_data_o=0, SS_n_o=11, pending flags=0, RR pointer=0, hold timer=0, state IDLE.
- Reset is asynchronous at any time, including mid-transaction: all pending requests are dropped and the state returns to IDLE.
- Request capture:
  - wrt_i[i] sets pend[i] and latches that requester's data and hold bit.
  - A wrt_i[i] while pend[i] is already set is ignored; the first request wins.
- IDLE:
  - If any pend is set, choose the winner. One pend set: that requester. Both set: the requester indicated by the RR pointer.
  - Next cycle: set gnt_o, pulse m_wrt for exactly one cycle with the latched data, clear pend[winner], go to BUSY.
  - Latency: wrt_i at cycle N in IDLE with nothing pending gives m_wrt at N+1 and gnt_o valid at N+1.
- BUSY:
  - Wait for m_done.
  - On m_done: register m_rd_data into rd_data_o and pulse done_o[winner] in the next cycle.
  - The RR pointer moves to the other requester.
  - If the latched hold=1, go to HOLD with the timer loaded to HOLD_TMO. Otherwise clear gnt_o and go to IDLE.
- HOLD:
  - gnt_o stays at the holder.
  - If pend[holder] is set, pulse m_wrt with its data next cycle and go to BUSY. This allows a minimum one-cycle gap, which the A2D requires.
  - Otherwise decrement the timer; at 0, clear gnt_o and go to IDLE.
  - The other requester's wrt is latched as pending but is not served until release.
- Simultaneous events:
  - wrt_i and a done_o on the same requester in the same cycle: the new request is captured normally.
  - Both wrt_i bits in the same cycle: both are captured and served in RR order.
- m_done outside BUSY is ignored.
- A m_done arriving in the same cycle as a held grant's release cannot occur, since HOLD is entered only after done.
- gnt_o is never two-hot. m_wrt is never asserted outside the IDLE→BUSY or HOLD→BUSY transitions.

Optional Feature:
SPI_ARB_CNT_EN
- Defined: adds outputs gnt_cnt0_o[15:0] and gnt_cnt1_o[15:0].
  - Each counts m_wrt pulses issued for that requester.
  - Counters saturate at 16'hFFFF and reset to 0.
  - A cnt_clr_i input (1 bit) clears both counters synchronously; cnt_clr_i has priority over increment.
- Undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Single request: wrt_i=01, wt_data0_i=16'h2000, hold=0 → m_wrt at N+1 with m_wt_data=16'h2000, gnt_o=01. Model returns m_rd_data=16'h0ABC → done_o=01 for one cycle, rd_data_o=16'h0ABC, gnt_o=00.
- Simultaneous requests after reset: wrt_i=11 → requester 0 is served first, then requester 1, each with one m_wrt. SS_n_o[1] stays high during requester 0's transfer.
- Hold pair: requester 0 issues wrt with hold=1, then a second wrt 1 cycle after done_o; requester 1 requests during the first transfer → requester 1 is not granted until requester 0's second done; gnt_o stays 01 throughout.
- Hold timeout with HOLD_TMO=8: requester 0 issues hold=1 and no follow-up → gnt_o returns to 00 exactly 8 cycles after entering HOLD; pending requester 1 is granted next.
- Dropped duplicate: requester 1 issues two wrt pulses while busy with requester 0 → only one requester 1 transaction occurs, using the first latched data.
- Reset mid-BUSY: assert rst during a transfer → gnt_o=00, SS_n_o=11, m_wrt=0 immediately; pendings cleared; no done_o after reset release.
